// File: rtl/bist_pkg.sv
// Shared types and constants for the combinational-netlist BIST harness.
// Tap masks mark the bits XOR-ed into the shift-in feedback bit.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_APPLY   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } bist_state_e;

  // x^14+x^5+x^3+x+1 taps bits 13,4,2,0; x^8+x^6+x^5+x^4+1 taps bits 7,5,4,3
  localparam logic [13:0] LFSR_TAPS = 14'h2015;
  localparam logic [7:0]  MISR_TAPS = 8'hB8;

  localparam int CNT_W = 16;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: shift left with tap feedback, XOR in data.
// Clear has priority over enable so a restart always begins from a zero seed.
module bist_misr #(
  parameter int             W    = 8,
  parameter logic [W-1:0]   TAPS = 8'hB8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] sig_o,
  output logic [W-1:0] sig_nxt_o
);

  logic [W-1:0] sig_q;

  assign sig_nxt_o = {sig_q[W-2:0], ^(sig_q & TAPS)} ^ data_i;
  assign sig_o     = sig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else if (clr_i) begin
      sig_q <= '0;
    end else if (en_i) begin
      sig_q <= sig_nxt_o;
    end
  end

endmodule

// File: rtl/comb_bist_ctrl.sv
// BIST controller: LFSR patterns into the mapped netlist, MISR on its outputs,
// signature compare at the end of a run.
//
// state   | meaning
// IDLE    | waiting for start after reset
// APPLY   | pattern on pat_out, settle counter running
// CAPTURE | absorb resp_in, count pattern, advance LFSR
// DONE    | results held; start re-runs
module comb_bist_ctrl
  import bist_pkg::*;
#(
  parameter int              IN_W       = 14,
  parameter int              OUT_W      = 8,
  parameter int              N_PATTERNS = 256,
  parameter int              SETTLE_CYC = 2,
  parameter logic [IN_W-1:0] LFSR_SEED  = 14'h0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OUT_W-1:0] exp_sig,
  output logic [IN_W-1:0]  pat_out,
  input  logic [OUT_W-1:0] resp_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature,
  output logic [CNT_W-1:0] pat_cnt
);

  localparam logic [15:0]      SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(N_PATTERNS);
  localparam logic [IN_W-1:0]  LFSR_MASK   = IN_W'(LFSR_TAPS);
  localparam logic [OUT_W-1:0] MISR_MASK   = OUT_W'(MISR_TAPS);

  bist_state_e      state_q, state_d;
  logic [IN_W-1:0]  lfsr_q, lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      settle_q, settle_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             misr_en, misr_clr;
  logic [OUT_W-1:0] sig_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic [IN_W-1:0]  lfsr_step;

  assign cnt_inc   = cnt_q + 1'b1;
  assign lfsr_step = {lfsr_q[IN_W-2:0], ^(lfsr_q & LFSR_MASK)};

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    done_d   = done_q;
    pass_d   = pass_q;
    misr_en  = 1'b0;
    misr_clr = 1'b0;

    case (state_q)
      ST_APPLY: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = ST_CAPTURE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        misr_en = 1'b1;
        cnt_d   = cnt_inc;
        lfsr_d  = lfsr_step;
        if (cnt_inc == CNT_LAST) begin
          state_d = ST_DONE;
          pass_d  = (sig_nxt == exp_sig);
        end else begin
          state_d = ST_APPLY;
        end
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // IDLE and DONE share the restart path; done drops on the start edge
    if ((state_q == ST_IDLE || state_q == ST_DONE) && start) begin
      state_d  = ST_APPLY;
      lfsr_d   = LFSR_SEED;
      cnt_d    = '0;
      settle_d = '0;
      done_d   = 1'b0;
      pass_d   = 1'b0;
      misr_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  bist_misr #(
    .W    (OUT_W),
    .TAPS (MISR_MASK)
  ) u_misr (
    .clk       (clk),
    .rst       (rst),
    .en_i      (misr_en),
    .clr_i     (misr_clr),
    .data_i    (resp_in),
    .sig_o     (signature),
    .sig_nxt_o (sig_nxt)
  );

  assign pat_out = lfsr_q;
  assign pat_cnt = cnt_q;
  assign busy    = (state_q == ST_APPLY) || (state_q == ST_CAPTURE);
  assign done    = done_q;
  assign pass    = pass_q & done_q;

endmodule

// File: tb/tb_comb_bist_ctrl.sv
// Self-checking bench: three controller instances (random-response run set,
// constant A5 response, constant zero response) against a cycle-indexed model.
module tb_comb_bist_ctrl;

  localparam int NA   = 4;
  localparam int SA   = 2;
  localparam int PER  = SA + 1;
  localparam int TEND = NA * PER;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, want);
    end
  endtask

  function automatic logic [13:0] lfsr_nth(input int k);
    logic [13:0] x;
    x = 14'h0001;
    for (int i = 0; i < k; i++) x = {x[12:0], x[13] ^ x[4] ^ x[2] ^ x[0]};
    return x;
  endfunction

  // stand-in for the mapped netlist: a fixed mixing of the pattern plus a key
  function automatic logic [7:0] net_of(input logic [13:0] p, input logic [7:0] key);
    return p[7:0] ^ p[13:6] ^ {p[2:0], p[12:8]} ^ key;
  endfunction

  function automatic logic [7:0] sig_after(input int k, input logic [7:0] key);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < k; i++)
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ net_of(lfsr_nth(i), key);
    return s;
  endfunction

  // instance A
  logic        start_a = 1'b0;
  logic [7:0]  exp_a = '0, key_a = '0;
  logic [13:0] pat_a;
  logic [7:0]  resp_a, sig_a;
  logic        busy_a, done_a, pass_a;
  logic [15:0] cnt_a;
  assign resp_a = net_of(pat_a, key_a);

  comb_bist_ctrl #(.IN_W(14), .OUT_W(8), .N_PATTERNS(NA), .SETTLE_CYC(SA),
                   .LFSR_SEED(14'h0001)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .exp_sig(exp_a), .pat_out(pat_a),
    .resp_in(resp_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .signature(sig_a), .pat_cnt(cnt_a));

  // instance B
  logic        start_b = 1'b0;
  logic [7:0]  exp_b = '0;
  logic [13:0] pat_b;
  logic [7:0]  sig_b;
  logic        busy_b, done_b, pass_b;
  logic [15:0] cnt_b;

  comb_bist_ctrl #(.IN_W(14), .OUT_W(8), .N_PATTERNS(2), .SETTLE_CYC(2),
                   .LFSR_SEED(14'h0001)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .exp_sig(exp_b), .pat_out(pat_b),
    .resp_in(8'hA5), .busy(busy_b), .done(done_b), .pass(pass_b),
    .signature(sig_b), .pat_cnt(cnt_b));

  // instance C
  logic        start_c = 1'b0;
  logic [13:0] pat_c;
  logic [7:0]  sig_c;
  logic        busy_c, done_c, pass_c;
  logic [15:0] cnt_c;

  comb_bist_ctrl #(.IN_W(14), .OUT_W(8), .N_PATTERNS(256), .SETTLE_CYC(2),
                   .LFSR_SEED(14'h0001)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .exp_sig(8'h00), .pat_out(pat_c),
    .resp_in(8'h00), .busy(busy_c), .done(done_c), .pass(pass_c),
    .signature(sig_c), .pat_cnt(cnt_c));

  task automatic chk_a_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy_a), 32'(0));
    chk({tag, "_done"}, 32'(done_a), 32'(0));
    chk({tag, "_pass"}, 32'(pass_a), 32'(0));
    chk({tag, "_pat"},  32'(pat_a),  32'(0));
    chk({tag, "_cnt"},  32'(cnt_a),  32'(0));
    chk({tag, "_sig"},  32'(sig_a),  32'(0));
  endtask

  // one run on A, checked every cycle; inj: cycle to pulse start while busy,
  // abort_at: cycle to assert rst (both -1 to disable)
  task automatic run_a(input int inj, input int abort_at, input bit good);
    logic [7:0] fin;
    int k;
    fin   = sig_after(NA, key_a);
    exp_a = good ? fin : (fin ^ (8'h01 << $urandom_range(7, 0)));
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int t = 0; t <= TEND + 2; t++) begin
      if (t > 0) begin
        @(posedge clk); #1;
      end
      k = (t < TEND) ? t / PER : NA;
      chk("a_busy", 32'(busy_a), 32'(t < TEND));
      chk("a_done", 32'(done_a), 32'(t >= TEND + 1));
      chk("a_pat",  32'(pat_a),  32'(lfsr_nth(k)));
      chk("a_cnt",  32'(cnt_a),  32'(k));
      chk("a_sig",  32'(sig_a),  32'(sig_after(k, key_a)));
      if (t >= TEND + 1) chk("a_pass", 32'(pass_a), 32'(good));
      if (t == abort_at) begin
        rst = 1'b1;
        #1;
        chk_a_zero("a_abort");
        #2;
        rst = 1'b0;
        return;
      end
      start_a = (t == inj);
    end
    start_a = 1'b0;
  endtask

  task automatic run_b(input logic [7:0] e);
    exp_b   = e;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      @(posedge clk); #1;
      if (t == 3) chk("b_sig1", 32'(sig_b), 32'h0000_00A5);
      if (t == 6) begin
        chk("b_sig2", 32'(sig_b), 32'h0000_00EF);
        chk("b_done_early", 32'(done_b), 32'(0));
      end
      if (t == 7) begin
        chk("b_done", 32'(done_b), 32'(1));
        chk("b_cnt",  32'(cnt_b),  32'(2));
        chk("b_pass", 32'(pass_b), 32'(e == 8'hEF));
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_a_zero("rst_a");
    chk("rst_b_busy", 32'(busy_b), 32'(0));
    chk("rst_c_done", 32'(done_c), 32'(0));

    run_b(8'hEF);
    run_b(8'hEE);

    start_c = 1'b1;
    @(posedge clk); #1;
    start_c = 1'b0;
    for (int t = 1; t <= 770; t++) begin
      @(posedge clk); #1;
      if (t == 768) chk("c_done_early", 32'(done_c), 32'(0));
    end
    chk("c_done", 32'(done_c), 32'(1));
    chk("c_sig",  32'(sig_c),  32'(0));
    chk("c_cnt",  32'(cnt_c),  32'(256));
    chk("c_pass", 32'(pass_c), 32'(1));

    key_a = 8'h00;
    run_a(-1, -1, 1'b1);
    for (int r = 0; r < 8; r++) begin
      key_a = 8'($urandom);
      run_a((r % 2 == 1) ? int'($urandom_range(0, TEND - 1)) : -1, -1, 1'($urandom_range(0, 1)));
    end
    key_a = 8'($urandom);
    run_a(-1, 7, 1'b1);
    run_a(-1, -1, 1'b1);
    run_a(4, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/comb_bist_ctrl.md
# comb_bist_ctrl

Built-in self-test controller that sits directly in front of and behind the 14-input / 8-output combinational mapped netlist. It drives pseudo-random 14-bit input patterns from an LFSR onto the netlist inputs, waits a programmable settle time, and compacts the 8-bit netlist response into a MISR signature. At the end of a run it compares the signature against an expected value and reports pass/fail. It is the sequential harness the team uses to check each re-mapped netlist on silicon and in gate-level simulation.

## Interface
Parameters:
- `IN_W`, default 14: pattern width, equal to the netlist input count.
- `OUT_W`, default 8: response width, equal to the netlist output count.
- `N_PATTERNS`, default 256: patterns per run; range 1..65535.
- `SETTLE_CYC`, default 2: cycles each pattern is held before capture; must be ≥1.
- `LFSR_SEED`, default 14'h0001: non-zero LFSR start value.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: begin-run pulse. Sampled only in IDLE or DONE.
- `exp_sig`, in, OUT_W: expected final signature. Sampled at DONE entry.
- `pat_out`, out, IN_W: drives the netlist inputs.
- `resp_in`, in, OUT_W: netlist outputs.
- `busy`, out, 1: high in APPLY and CAPTURE.
- `done`, out, 1: high in DONE.
- `pass`, out, 1: valid while `done` is high; 1 when `signature == exp_sig`.
- `signature`, out, OUT_W: current MISR value.
- `pat_cnt`, out, 16: patterns captured so far.

## Operation
- FSM states: IDLE, APPLY, CAPTURE, DONE.
- Transitions:
  - IDLE or DONE with `start`=1 → APPLY. This loads `pat_out`=LFSR_SEED and clears `signature`, `pat_cnt` and the settle counter.
  - APPLY holds `pat_out` for SETTLE_CYC cycles, then → CAPTURE.
  - CAPTURE absorbs `resp_in` into the MISR, increments `pat_cnt` and advances the LFSR. Next state is DONE if the new `pat_cnt` equals N_PATTERNS, otherwise APPLY with the new pattern.
  - DONE holds `pat_out`, `signature` and `pat_cnt`, and drives `pass`.
- LFSR is Fibonacci, polynomial x^14+x^5+x^3+x+1.
  - next = {lfsr[12:0], lfsr[13]^lfsr[4]^lfsr[2]^lfsr[0]}.
  - Sequence from 0001: 0001, 0003, 0007, 000E, …
- MISR uses x^8+x^6+x^5+x^4+1.
  - next = {sig[6:0], sig[7]^sig[5]^sig[4]^sig[3]} ^ resp_in.
  - Seed is 0.
- `start` while `busy` is ignored; there is no abort other than `rst`.
- `pass` is a registered compare, computed on the CAPTURE→DONE transition from the final signature and `exp_sig`.

## Timing
- Reset values: state IDLE, `pat_out`=0, `signature`=0, `pat_cnt`=0, `busy`=`done`=`pass`=0.
- Reset mid-run returns to IDLE immediately and asynchronously, with all outputs at their reset values.
- Each pattern occupies SETTLE_CYC+1 cycles.
- `done` rises N_PATTERNS·(SETTLE_CYC+1)+1 clock edges after the edge that samples `start`.
- `resp_in` is sampled at the clock edge ending the CAPTURE cycle. The netlist path therefore has SETTLE_CYC+1 cycles to settle.
- `pat_out` changes only on the edge leaving CAPTURE, and on the start edge.
- `start` held high in DONE restarts on the next edge; `done` drops in that same cycle.
- `pat_cnt` does not wrap, because N_PATTERNS ≤ 65535.

## Structure
- Shared package `bist_pkg` holds:
  - the state enum;
  - LFSR and MISR tap masks (14'h2015, 8'hB8);
  - the `pat_cnt` width.
- One sub-module, `bist_misr`. It is parameterised by width and tap mask and has enable, clear and a data input.
- The LFSR stays inline in the controller.

## Test plan
- Reset, then idle 5 cycles → all outputs 0, `busy`=0.
- N_PATTERNS=4, SETTLE_CYC=2, `start` pulse → `pat_out` steps 0001, 0003, 0007, 000E. Each value is held 3 cycles. `done` rises 13 edges after start; `pat_cnt`=4.
- N_PATTERNS=2, `resp_in` tied to 8'hA5 → `signature`=A5 after the first capture and EF after the second. With `exp_sig`=EF, `pass`=1; with `exp_sig`=EE, `pass`=0.
- `resp_in` tied to 0, N_PATTERNS=256 → `signature`=00 and `pass`=1 when `exp_sig`=00.
- `rst` asserted in the middle of pattern 3 → outputs are reset in the same cycle. A subsequent `start` reproduces the exact run from pattern 0001.
- `start` pulsed while busy → ignored, with identical timing and signature. `start` pulsed in DONE → a clean rerun with the same final signature.
